// File: rtl/irq_pending_capture_if.sv
// Bundle between the request-capture stage and its driver/consumer.
//   req      : asynchronous request lines (n)
//   mask     : per-bit output enable (n)
//   ack      : clear strobe, qualified by ack_idx
//   ack_idx  : index of the pending bit to clear
//   w        : pending & mask, feeds the encoder w input
//   pending  : raw pending register
//   overflow : sticky per-bit "event arrived while already pending"
//   irq      : |w
interface irq_pending_capture_if #(
    parameter int unsigned n = 6
);
    localparam int unsigned idx_w = $clog2(n);

    logic [n-1:0]     req;
    logic [n-1:0]     mask;
    logic             ack;
    logic [idx_w-1:0] ack_idx;
    logic [n-1:0]     w;
    logic [n-1:0]     pending;
    logic [n-1:0]     overflow;
    logic             irq;

    modport master (
        output req, mask, ack, ack_idx,
        input  w, pending, overflow, irq
    );

    modport slave (
        input  req, mask, ack, ack_idx,
        output w, pending, overflow, irq
    );
endinterface

// File: rtl/irq_pending_capture.sv
// Request-capture stage in front of a priority encoder. Each request line is
// synchronised, its rising edge becomes a sticky pending bit, and the consumer
// clears one pending bit per cycle by acknowledging its index.
//   clk : clock, all state updates on rising edge
//   rst : asynchronous active-high reset
//   bus : irq_pending_capture_if slave (req/mask/ack/ack_idx in,
//         w/pending/overflow/irq out)
module irq_pending_capture #(
    parameter int unsigned n = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    irq_pending_capture_if.slave  bus
);
    localparam int unsigned idx_w = $clog2(n);

    logic [n-1:0] s1_q, s1_d;
    logic [n-1:0] s2_q, s2_d;
    logic [n-1:0] dly_q, dly_d;
    logic [n-1:0] pending_q, pending_d;
    logic [n-1:0] overflow_q, overflow_d;
    logic [n-1:0] rise;
    logic [n-1:0] ack_hit;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            dly_q      <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            dly_q      <= dly_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Synchroniser, edge detect and pending/overflow next state
    always_comb begin
        s1_d  = bus.req;
        s2_d  = s1_q;
        dly_d = s2_q;
        rise  = s2_q & ~dly_q;

        // An out-of-range index matches no bit, so it is ignored naturally
        ack_hit = '0;
        for (int i = 0; i < n; i++) begin
            ack_hit[i] = bus.ack && (bus.ack_idx == idx_w'(i));
        end

        // Set wins over a same-cycle clear
        pending_d  = rise | (pending_q & ~ack_hit);
        // Overflow clears only on an ack with no competing edge
        overflow_d = (overflow_q | (rise & pending_q & ~ack_hit))
                   & ~(ack_hit & ~rise);
    end

    assign bus.w        = pending_q & bus.mask;
    assign bus.irq      = |(pending_q & bus.mask);
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
module tb_irq_pending_capture;
    localparam int unsigned n = 6;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_pending_capture_if #(.n(n)) bus ();

    irq_pending_capture #(.n(n)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold bits high for two edges, drop, and return once pending is set and
    // the synchroniser has settled low again.
    task automatic pulse_capture(input logic [n-1:0] bits);
        bus.req = bus.req | bits;
        tick();
        tick();
        bus.req = bus.req & ~bits;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.req  = 6'b101010;
        bus.mask = 6'b111111;
        bus.ack  = 1'b0;
        bus.ack_idx = '0;
        tick(); tick(); tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL reset_pending got %b exp %b", bus.pending, 6'b000000); end
        checks++; if (bus.w !== 6'b000000) begin errors++; $display("FAIL reset_w got %b exp %b", bus.w, 6'b000000); end
        checks++; if (bus.overflow !== 6'b000000) begin errors++; $display("FAIL reset_overflow got %b exp %b", bus.overflow, 6'b000000); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp %b", bus.irq, 1'b0); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL release_early got %b exp %b", bus.pending, 6'b000000); end
        tick();
        checks++; if (bus.pending !== 6'b101010) begin errors++; $display("FAIL release_3clk got %b exp %b", bus.pending, 6'b101010); end
        bus.req = '0;
        bus.ack = 1'b1;
        bus.ack_idx = 3'd5; tick();
        bus.ack_idx = 3'd3; tick();
        bus.ack_idx = 3'd1; tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL reset_cleanup got %b exp %b", bus.pending, 6'b000000); end
        tick(); tick();
    endtask

    task automatic test_latency_mask();
        bus.mask = 6'b111111;
        bus.req  = 6'b010000;
        tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL lat_k got %b exp %b", bus.pending, 6'b000000); end
        tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL lat_k1 got %b exp %b", bus.pending, 6'b000000); end
        bus.req = '0;
        tick();
        checks++; if (bus.pending !== 6'b010000) begin errors++; $display("FAIL lat_k2 got %b exp %b", bus.pending, 6'b010000); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL lat_irq got %b exp %b", bus.irq, 1'b1); end
        checks++; if (bus.w !== 6'b010000) begin errors++; $display("FAIL lat_w got %b exp %b", bus.w, 6'b010000); end
        bus.mask = 6'b000000;
        #1;
        checks++; if (bus.w !== 6'b000000) begin errors++; $display("FAIL mask_w got %b exp %b", bus.w, 6'b000000); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp %b", bus.irq, 1'b0); end
        checks++; if (bus.pending !== 6'b010000) begin errors++; $display("FAIL mask_pending got %b exp %b", bus.pending, 6'b010000); end
        tick(); tick();
        bus.mask = 6'b111111;
        #1;
        checks++; if (bus.w !== 6'b010000) begin errors++; $display("FAIL unmask_w got %b exp %b", bus.w, 6'b010000); end
        bus.ack = 1'b1; bus.ack_idx = 3'd4;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL lat_cleanup got %b exp %b", bus.pending, 6'b000000); end
    endtask

    task automatic test_drain();
        pulse_capture(6'b100101);
        checks++; if (bus.pending !== 6'b100101) begin errors++; $display("FAIL drain_setup got %b exp %b", bus.pending, 6'b100101); end
        bus.ack = 1'b1;
        bus.ack_idx = 3'd5; tick();
        checks++; if (bus.pending !== 6'b000101) begin errors++; $display("FAIL drain_1 got %b exp %b", bus.pending, 6'b000101); end
        bus.ack_idx = 3'd2; tick();
        checks++; if (bus.pending !== 6'b000001) begin errors++; $display("FAIL drain_2 got %b exp %b", bus.pending, 6'b000001); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL drain_irq2 got %b exp %b", bus.irq, 1'b1); end
        bus.ack_idx = 3'd0; tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL drain_3 got %b exp %b", bus.pending, 6'b000000); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL drain_irq3 got %b exp %b", bus.irq, 1'b0); end
        bus.ack = 1'b0;
    endtask

    task automatic test_overflow();
        pulse_capture(6'b000100);
        checks++; if (bus.overflow !== 6'b000000) begin errors++; $display("FAIL ovf_first got %b exp %b", bus.overflow, 6'b000000); end
        pulse_capture(6'b000100);
        checks++; if (bus.overflow !== 6'b000100) begin errors++; $display("FAIL ovf_set got %b exp %b", bus.overflow, 6'b000100); end
        checks++; if (bus.pending !== 6'b000100) begin errors++; $display("FAIL ovf_pending got %b exp %b", bus.pending, 6'b000100); end
        bus.ack = 1'b1; bus.ack_idx = 3'd2;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL ovf_ack_pending got %b exp %b", bus.pending, 6'b000000); end
        checks++; if (bus.overflow !== 6'b000000) begin errors++; $display("FAIL ovf_ack_clear got %b exp %b", bus.overflow, 6'b000000); end
    endtask

    task automatic test_collision();
        pulse_capture(6'b000010);
        bus.req = 6'b000010;
        tick();
        tick();
        // edge on bit 1 is live in this cycle; ack it at the same time
        bus.req = '0;
        bus.ack = 1'b1; bus.ack_idx = 3'd1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000010) begin errors++; $display("FAIL coll_pending got %b exp %b", bus.pending, 6'b000010); end
        checks++; if (bus.overflow !== 6'b000000) begin errors++; $display("FAIL coll_overflow got %b exp %b", bus.overflow, 6'b000000); end
        tick(); tick();
        bus.ack = 1'b1; bus.ack_idx = 3'd1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL coll_cleanup got %b exp %b", bus.pending, 6'b000000); end
    endtask

    task automatic test_illegal_ack();
        pulse_capture(6'b000100);
        pulse_capture(6'b000100);
        bus.ack = 1'b1; bus.ack_idx = 3'd7;
        tick();
        checks++; if (bus.pending !== 6'b000100) begin errors++; $display("FAIL illegal_pending got %b exp %b", bus.pending, 6'b000100); end
        checks++; if (bus.overflow !== 6'b000100) begin errors++; $display("FAIL illegal_overflow got %b exp %b", bus.overflow, 6'b000100); end
        bus.ack_idx = 3'd3;
        tick();
        checks++; if (bus.pending !== 6'b000100) begin errors++; $display("FAIL nonpend_pending got %b exp %b", bus.pending, 6'b000100); end
        checks++; if (bus.overflow !== 6'b000100) begin errors++; $display("FAIL nonpend_overflow got %b exp %b", bus.overflow, 6'b000100); end
        bus.ack_idx = 3'd2;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL illegal_cleanup got %b exp %b", bus.pending, 6'b000000); end
    endtask

    task automatic test_mid_reset();
        pulse_capture(6'b001000);
        checks++; if (bus.pending !== 6'b001000) begin errors++; $display("FAIL midrst_setup got %b exp %b", bus.pending, 6'b001000); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL midrst_async got %b exp %b", bus.pending, 6'b000000); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp %b", bus.irq, 1'b0); end
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (bus.pending !== 6'b000000) begin errors++; $display("FAIL midrst_after got %b exp %b", bus.pending, 6'b000000); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency_mask();
        test_drain();
        test_overflow();
        test_collision();
        test_illegal_ack();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
